// File: rtl/qk_score_stage_if.sv
// rtl/qk_score_stage_if.sv - element-serial Q/K input and score output handshake bundle
interface qk_score_stage_if #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 16,
    parameter int IDX_W  = 4
);
    logic                     q_valid;
    logic                     q_ready;
    logic signed [DATA_W-1:0] q_data;
    logic                     k_valid;
    logic                     k_ready;
    logic signed [DATA_W-1:0] k_data;
    logic                     s_valid;
    logic                     s_ready;
    logic signed [OUT_W-1:0]  s_data;
    logic [IDX_W-1:0]         s_idx;
    logic                     s_last;
    logic                     s_sat;

    modport slave (
        input  q_valid, q_data, k_valid, k_data, s_ready,
        output q_ready, k_ready, s_valid, s_data, s_idx, s_last, s_sat
    );

    modport master (
        output q_valid, q_data, k_valid, k_data, s_ready,
        input  q_ready, k_ready, s_valid, s_data, s_idx, s_last, s_sat
    );
endinterface

// File: rtl/qk_score_stage.sv
// rtl/qk_score_stage.sv - latches one query vector and emits one Q.K score per streamed key token
// Optional score saturation enabled by defining QK_SCORE_SAT_EN; otherwise the score wraps.
module qk_score_stage #(
    parameter int DATA_W = 8,
    parameter int KDIM   = 4,
    parameter int N_TOK  = 16,
    parameter int OUT_W  = 16,
    parameter int ACC_W  = 2*DATA_W + $clog2(KDIM)
) (
    input  logic                clk,
    input  logic                rst,
    qk_score_stage_if.slave     bus,
    output logic                busy
);
    localparam int KCNT_W = (KDIM  > 1) ? $clog2(KDIM)  : 1;
    localparam int IDX_W  = (N_TOK > 1) ? $clog2(N_TOK) : 1;
    localparam int PROD_W = 2*DATA_W;
    localparam logic [KCNT_W-1:0] K_LAST = KCNT_W'(KDIM - 1);
    localparam logic [IDX_W-1:0]  T_LAST = IDX_W'(N_TOK - 1);

    typedef enum logic [1:0] {
        LOAD_Q = 2'd0,
        ACC    = 2'd1,
        EMIT   = 2'd2
    } state_t;

    state_t                    r_state;
    logic signed [DATA_W-1:0]  r_q_reg [KDIM];
    logic [KCNT_W-1:0]         r_q_cnt;
    logic [KCNT_W-1:0]         r_k_cnt;
    logic [IDX_W-1:0]          r_tok_cnt;
    logic signed [ACC_W-1:0]   r_acc;
    logic                      r_q_ready;
    logic                      r_k_ready;
    logic                      r_s_valid;
    logic signed [OUT_W-1:0]   r_s_data;
    logic                      r_s_last;
    logic                      r_s_sat;

    logic signed [PROD_W-1:0]  w_prod;
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [OUT_W-1:0]   w_score;
    logic                      w_clip;

    // Full-precision signed MAC; the sum including the current beat feeds both acc and the output.
    assign w_prod = PROD_W'(r_q_reg[r_k_cnt]) * PROD_W'(bus.k_data);
    assign w_sum  = r_acc + ACC_W'(w_prod);

    generate
        if (OUT_W >= ACC_W) begin : g_ext
            assign w_score = OUT_W'(w_sum);
            assign w_clip  = 1'b0;
        end else begin : g_conv
`ifdef QK_SCORE_SAT_EN
            localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
            localparam logic signed [ACC_W-1:0] MIN_V = -MAX_V - ACC_W'(1);
            logic w_hi;
            logic w_lo;
            assign w_hi    = (w_sum > MAX_V);
            assign w_lo    = (w_sum < MIN_V);
            assign w_clip  = w_hi | w_lo;
            assign w_score = w_hi ? MAX_V[OUT_W-1:0] :
                             w_lo ? MIN_V[OUT_W-1:0] : w_sum[OUT_W-1:0];
`else
            assign w_score = w_sum[OUT_W-1:0];
            assign w_clip  = 1'b0;
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= LOAD_Q;
            r_q_cnt   <= '0;
            r_k_cnt   <= '0;
            r_tok_cnt <= '0;
            r_acc     <= '0;
            r_q_ready <= 1'b0;
            r_k_ready <= 1'b0;
            r_s_valid <= 1'b0;
            r_s_data  <= '0;
            r_s_last  <= 1'b0;
            r_s_sat   <= 1'b0;
        end else begin
            unique case (r_state)
                LOAD_Q: begin
                    r_q_ready <= 1'b1;
                    if (bus.q_valid && r_q_ready) begin
                        r_q_reg[r_q_cnt] <= bus.q_data;
                        if (r_q_cnt == K_LAST) begin
                            r_q_cnt   <= '0;
                            r_k_cnt   <= '0;
                            r_tok_cnt <= '0;
                            r_acc     <= '0;
                            r_q_ready <= 1'b0;
                            r_k_ready <= 1'b1;
                            r_state   <= ACC;
                        end else begin
                            r_q_cnt <= r_q_cnt + KCNT_W'(1);
                        end
                    end
                end
                ACC: begin
                    if (bus.k_valid && r_k_ready) begin
                        r_acc <= w_sum;
                        if (r_k_cnt == K_LAST) begin
                            r_k_cnt   <= '0;
                            r_k_ready <= 1'b0;
                            r_s_valid <= 1'b1;
                            r_s_data  <= w_score;
                            r_s_sat   <= w_clip;
                            r_s_last  <= (r_tok_cnt == T_LAST);
                            r_state   <= EMIT;
                        end else begin
                            r_k_cnt <= r_k_cnt + KCNT_W'(1);
                        end
                    end
                end
                EMIT: begin
                    if (bus.s_ready && r_s_valid) begin
                        r_s_valid <= 1'b0;
                        r_s_last  <= 1'b0;
                        if (r_s_last) begin
                            r_q_cnt   <= '0;
                            r_q_ready <= 1'b1;
                            r_state   <= LOAD_Q;
                        end else begin
                            r_tok_cnt <= r_tok_cnt + IDX_W'(1);
                            r_acc     <= '0;
                            r_k_ready <= 1'b1;
                            r_state   <= ACC;
                        end
                    end
                end
                default: r_state <= LOAD_Q;
            endcase
        end
    end

    assign bus.q_ready = r_q_ready;
    assign bus.k_ready = r_k_ready;
    assign bus.s_valid = r_s_valid;
    assign bus.s_data  = r_s_data;
    assign bus.s_idx   = r_tok_cnt;
    assign bus.s_last  = r_s_last;
    assign bus.s_sat   = r_s_sat;
    assign busy        = !((r_state == LOAD_Q) && (r_q_cnt == '0));
endmodule

// File: tb/tb_qk_score_stage.sv
// tb/tb_qk_score_stage.sv - directed and randomized-bubble checks of qk_score_stage
module tb_qk_score_stage;
    localparam int DATA_W = 8;
    localparam int KDIM   = 4;
    localparam int N_TOK  = 16;
    localparam int OUT_W  = 16;
    localparam int IDX_W  = 4;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    qk_score_stage_if #(.DATA_W(DATA_W), .OUT_W(OUT_W), .IDX_W(IDX_W)) bus ();

    qk_score_stage #(
        .DATA_W(DATA_W), .KDIM(KDIM), .N_TOK(N_TOK), .OUT_W(OUT_W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic signed [31:0] ref_score(input int s);
`ifdef QK_SCORE_SAT_EN
        if (s > 32767)  return 32767;
        if (s < -32768) return -32768;
        return s;
`else
        logic [15:0] w;
        w = s[15:0];
        return 32'($signed(w));
`endif
    endfunction

    function automatic logic signed [31:0] ref_sat(input int s);
`ifdef QK_SCORE_SAT_EN
        return (s > 32767 || s < -32768) ? 1 : 0;
`else
        return (s == s) ? 0 : 1;
`endif
    endfunction

    task automatic push_q(input int v, input bit bub);
        int n = 0;
        bit acc = 1'b0;
        if (bub && $urandom_range(1) == 1) begin
            bus.q_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.q_valid = 1'b1;
        bus.q_data  = 8'(v);
        while (!acc && n < 100) begin
            @(negedge clk); acc = bus.q_ready;
            @(posedge clk); #1; n++;
        end
        bus.q_valid = 1'b0;
        if (!acc) check("q_timeout", 0, 1);
    endtask

    task automatic push_k(input int v, input bit bub, output int cycles);
        int n = 0;
        bit acc = 1'b0;
        if (bub && $urandom_range(1) == 1) begin
            bus.k_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.k_valid = 1'b1;
        bus.k_data  = 8'(v);
        while (!acc && n < 100) begin
            @(negedge clk); acc = bus.k_ready;
            @(posedge clk); #1; n++;
        end
        bus.k_valid = 1'b0;
        cycles = n;
        if (!acc) check("k_timeout", 0, 1);
    endtask

    task automatic get_score(input bit rnd, output logic signed [31:0] d, output logic signed [31:0] idx,
                             output logic signed [31:0] last, output logic signed [31:0] sat);
        int n = 0;
        bit got = 1'b0;
        d = 'x; idx = 'x; last = 'x; sat = 'x;
        while (!got && n < 100) begin
            bus.s_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) begin
                got  = 1'b1;
                d    = 32'($signed(bus.s_data));
                idx  = 32'(bus.s_idx);
                last = 32'(bus.s_last);
                sat  = 32'(bus.s_sat);
            end
            @(posedge clk); #1; n++;
        end
        bus.s_ready = 1'b0;
        if (!got) check("score_timeout", 0, 1);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        logic signed [31:0] d, idx, last, sat;
        int cyc;
        int qv [KDIM];
        int kv [KDIM];
        int sum;

        rst = 1'b1;
        bus.q_valid = 1'b0; bus.q_data = '0;
        bus.k_valid = 1'b0; bus.k_data = '0;
        bus.s_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_valid", bus.s_valid, 0);
        check("rst_s_data",  bus.s_data, 0);
        check("rst_s_idx",   bus.s_idx, 0);
        check("rst_s_last",  bus.s_last, 0);
        check("rst_s_sat",   bus.s_sat, 0);
        check("rst_q_ready", bus.q_ready, 0);
        check("rst_k_ready", bus.k_ready, 0);
        check("rst_busy",    busy, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_q_ready", bus.q_ready, 1);

        // q={1,2,3,4} against 16 all-ones keys: every score is 10.
        for (int i = 0; i < KDIM; i++) push_q(i + 1, 1'b0);
        check("acc_k_ready", bus.k_ready, 1);
        check("acc_q_ready", bus.q_ready, 0);
        check("acc_busy",    busy, 1);
        for (int t = 0; t < N_TOK; t++) begin
            for (int e = 0; e < KDIM; e++) push_k(1, 1'b0, cyc);
            get_score(1'b0, d, idx, last, sat);
            check("ones_data", d, 10);
            check("ones_idx",  idx, t);
            check("ones_last", last, (t == N_TOK - 1) ? 1 : 0);
        end
        check("ones_done_q_ready", bus.q_ready, 1);
        check("ones_done_busy",    busy, 0);

        // Mixed-sign vector, latency and back-pressure hold.
        push_q(-1, 1'b0); push_q(2, 1'b0); push_q(-3, 1'b0); push_q(4, 1'b0);
        push_k(5, 1'b0, cyc); push_k(6, 1'b0, cyc); push_k(7, 1'b0, cyc);
        push_k(8, 1'b0, cyc);
        check("lat_s_valid", bus.s_valid, 1);
        check("mix_data", $signed(bus.s_data), 18);
        check("mix_idx",  bus.s_idx, 0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("stall_valid",   bus.s_valid, 1);
            check("stall_data",    $signed(bus.s_data), 18);
            check("stall_idx",     bus.s_idx, 0);
            check("stall_k_ready", bus.k_ready, 0);
        end
        get_score(1'b0, d, idx, last, sat);
        check("stall_xfer_data", d, 18);
        check("after_xfer_valid",   bus.s_valid, 0);
        check("after_xfer_k_ready", bus.k_ready, 1);
        push_k(1, 1'b0, cyc);
        check("next_key_cycles", cyc, 1);
        pulse_rst();
        @(posedge clk); #1;

        // Extreme operands: 4 * 16384 = 65536 overflows a 16-bit score.
        for (int i = 0; i < KDIM; i++) push_q(-128, 1'b0);
        for (int i = 0; i < KDIM; i++) push_k(-128, 1'b0, cyc);
        get_score(1'b0, d, idx, last, sat);
`ifdef QK_SCORE_SAT_EN
        check("ovf_data", d, 32767);
        check("ovf_sat",  sat, 1);
`else
        check("ovf_data", d, 0);
        check("ovf_sat",  sat, 0);
`endif
        pulse_rst();
        @(posedge clk); #1;

        // Reset mid-token discards the query.
        for (int i = 0; i < KDIM; i++) push_q(3, 1'b0);
        push_k(1, 1'b0, cyc); push_k(1, 1'b0, cyc);
        pulse_rst();
        check("abort_s_valid_0", bus.s_valid, 0);
        check("abort_q_ready_0", bus.q_ready, 0);
        @(posedge clk); #1;
        check("abort_s_valid_1", bus.s_valid, 0);
        check("abort_q_ready_1", bus.q_ready, 1);
        check("abort_busy",      busy, 0);
        for (int i = 0; i < KDIM; i++) push_q(1, 1'b0);
        for (int i = 0; i < KDIM; i++) push_k(2, 1'b0, cyc);
        get_score(1'b0, d, idx, last, sat);
        check("abort_new_data", d, 8);
        check("abort_new_idx",  idx, 0);
        pulse_rst();
        @(posedge clk); #1;

        // Random operands with valid bubbles and random back-pressure.
        for (int i = 0; i < KDIM; i++) begin
            qv[i] = int'($urandom_range(255)) - 128;
            push_q(qv[i], 1'b1);
        end
        for (int t = 0; t < N_TOK; t++) begin
            sum = 0;
            for (int e = 0; e < KDIM; e++) begin
                kv[e] = int'($urandom_range(255)) - 128;
                sum += qv[e] * kv[e];
                push_k(kv[e], 1'b1, cyc);
            end
            get_score(1'b1, d, idx, last, sat);
            check("rnd_data", d, ref_score(sum));
            check("rnd_sat",  sat, ref_sat(sum));
            check("rnd_idx",  idx, t);
            check("rnd_last", last, (t == N_TOK - 1) ? 1 : 0);
        end
        check("rnd_done_q_ready", bus.q_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
